// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared helpers for pwm_multi (tick divider, duty array type, ramp step; PWM_RAMP_EN)
`ifndef PWM_PKG_SV
`define PWM_PKG_SV

// Packed per-channel duty array: element i is the duty code of channel i.
`define PWM_DUTY_ARR(ch, w) logic [(ch)-1:0][(w)-1:0]

package pwm_pkg;

    // Smallest usable tick divider; below this the timebase cannot resolve a step.
    localparam int unsigned PWM_MIN_TICK = 2;

    // Clocks per duty step: one PWM period is split into 2**width equal steps.
    function automatic int unsigned tick_count(input int unsigned clock_hz,
                                               input int unsigned freq_hz,
                                               input int unsigned width);
        return (clock_hz / freq_hz) / (32'd1 << width);
    endfunction

    // Move cur toward target by at most max_step, never overshooting.
    function automatic int unsigned ramp_toward(input int unsigned cur,
                                                input int unsigned target,
                                                input int unsigned max_step);
        int unsigned diff;
        if (target >= cur) begin
            diff = target - cur;
            return cur + ((diff < max_step) ? diff : max_step);
        end
        diff = cur - target;
        return cur - ((diff < max_step) ? diff : max_step);
    endfunction

endpackage

`endif

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared tick/step timebase with period end and period start flags
import pwm_pkg::*;

module pwm_timebase #(
    parameter int TICK  = 62,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] step,
    output logic             period_end,
    output logic             period_start
);

    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

    logic [TW-1:0] tick;
    logic          at_zero;
    // Set when the counters land on step 0 of a new period; cleared once
    // the start pulse has been issued so a pause at 0/0 cannot repeat it.
    logic          fresh;

    assign period_end = en && (tick == TICK_LAST) && (step == '1);
    assign at_zero    = (tick == '0) && (step == '0);

    // Tick/step counters advance only while enabled and hold otherwise.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            tick <= '0;
            step <= '0;
        end else if (en) begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                step <= step + WIDTH'(1);
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Registered period start, aligned with the pwm outputs showing step 0.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            period_start <= 1'b0;
            fresh        <= 1'b1;
        end else begin
            period_start <= en && at_zero && fresh;
            if (period_end) begin
                fresh <= 1'b1;
            end else if (en && at_zero) begin
                fresh <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N-channel double-buffered PWM with per-channel polarity; PWM_RAMP_EN enables ramped commits
import pwm_pkg::*;

module pwm_multi #(
    parameter  int CLOCK     = 50000000,
    parameter  int FREQ      = 100,
    parameter  int WIDTH     = 8,
    parameter  int CHANNELS  = 4,
    parameter  int RAMP_STEP = 1,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] invert,
    output logic                wr_err,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm
);

    localparam int TICK = tick_count(CLOCK, FREQ, WIDTH);
    localparam logic [CW:0] CHAN_LIM = (CW + 1)'(CHANNELS);

    if (TICK < PWM_MIN_TICK) begin : g_tick_err
        $error("pwm_multi: CLOCK/FREQ too small for WIDTH, tick divider below 2");
    end
    if (RAMP_STEP < 1) begin : g_ramp_err
        $error("pwm_multi: RAMP_STEP must be at least 1");
    end

    `PWM_DUTY_ARR(CHANNELS, WIDTH) shadow;
    `PWM_DUTY_ARR(CHANNELS, WIDTH) active;
    `PWM_DUTY_ARR(CHANNELS, WIDTH) commit_val;

    logic [WIDTH-1:0]    step;
    logic                period_end;
    logic [CW:0]         wr_chan_ext;
    logic                wr_ok;
    logic [CHANNELS-1:0] raw;

    // Widened so an out-of-range channel is comparable for any CHANNELS.
    assign wr_chan_ext = {1'b0, wr_chan};
    assign wr_ok       = wr_chan_ext < CHAN_LIM;

    pwm_timebase #(
        .TICK  (TICK),
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk          (clk),
        .clr_n        (clr_n),
        .en           (en),
        .step         (step),
        .period_end   (period_end),
        .period_start (period_start)
    );

    // Value each active register takes at the period boundary.
    always_comb begin
        commit_val = active;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_RAMP_EN
            commit_val[i] = WIDTH'(ramp_toward(32'(active[i]), 32'(shadow[i]), RAMP_STEP));
`else
            commit_val[i] = shadow[i];
`endif
        end
    end

    // Raw comparator level; the all-ones code is forced fully active.
    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (active[i] == '1) || (step < active[i]);
        end
    end

    // Shadow writes land any time; active only changes at period end and
    // picks up the shadow value from before a same-cycle write.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (period_end) begin
                active <= commit_val;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && wr_ok && (wr_chan_ext == (CW + 1)'(i))) begin
                    shadow[i] <= wr_duty;
                end
            end
        end
    end

    // Output registers: polarity applied here, inactive level while disabled.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pwm    <= '0;
            wr_err <= 1'b0;
        end else begin
            pwm    <= en ? (raw ^ invert) : invert;
            wr_err <= wr_en && !wr_ok;
        end
    end

endmodule
